// File: rtl/bnn_pkg.sv
// Shared types for the BNN inference blocks: sequencer state encoding and
// layer-select codes presented to the neuron datapath.
package bnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_L1   = 3'd2,
    ST_L2   = 3'd3,
    ST_L3   = 3'd4,
    ST_DONE = 3'd5
  } bnn_state_e;

  localparam logic [1:0] LSEL_L1   = 2'd0;
  localparam logic [1:0] LSEL_L2   = 2'd1;
  localparam logic [1:0] LSEL_L3   = 2'd2;
  localparam logic [1:0] LSEL_NONE = 2'd0;

  localparam int RESULT_W = 4;

  function automatic logic [1:0] layer_code(input bnn_state_e st);
    logic [1:0] code;
    case (st)
      ST_L1:   code = LSEL_L1;
      ST_L2:   code = LSEL_L2;
      ST_L3:   code = LSEL_L3;
      default: code = LSEL_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bnn_layer_sequencer_if.sv
// Neuron request/acknowledge channel between the layer sequencer (master)
// and the popcount datapath (slave).
interface bnn_layer_sequencer_if #(
  parameter int IDX_W   = 7,
  parameter int SCORE_W = 10
) ();

  logic               nrn_req;
  logic [1:0]         layer_sel;
  logic [IDX_W-1:0]   nrn_idx;
  logic               nrn_ack;
  logic [SCORE_W-1:0] nrn_score;

  modport master (
    output nrn_req,
    output layer_sel,
    output nrn_idx,
    input  nrn_ack,
    input  nrn_score
  );

  modport slave (
    input  nrn_req,
    input  layer_sel,
    input  nrn_idx,
    output nrn_ack,
    output nrn_score
  );

endinterface

// File: rtl/bnn_argmax.sv
// Running-maximum tracker over the output layer; ties keep the earlier index
// and index 0 always seeds the maximum.
module bnn_argmax
  import bnn_pkg::*;
#(
  parameter int IDX_W   = 7,
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  input  logic [SCORE_W-1:0] score,
  output logic [IDX_W-1:0]   best_idx
);

  logic [SCORE_W-1:0] best_score_r;
  logic [IDX_W-1:0]   best_idx_r;
  logic               take_s;

  // Decide whether the presented score replaces the current maximum
  always_comb begin
    take_s = 1'b0;
    if (en) begin
      take_s = (idx == {IDX_W{1'b0}}) || (score > best_score_r);
    end else begin
      take_s = 1'b0;
    end
  end

  // Maximum score/index registers
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      best_score_r <= {SCORE_W{1'b0}};
      best_idx_r   <= {IDX_W{1'b0}};
    end else if (take_s) begin
      best_score_r <= score;
      best_idx_r   <= idx;
    end else begin
      best_score_r <= best_score_r;
      best_idx_r   <= best_idx_r;
    end
  end

  assign best_idx = best_idx_r;

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Walks the three BNN layers neuron by neuron, issuing one request per neuron
// with a bubble after each acknowledge, then reports the output-layer argmax.
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int L1_N    = 128,
  parameter int L2_N    = 64,
  parameter int L3_N    = 10,
  parameter int SCORE_W = 10,
  parameter int IDX_W   = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode,
  input  logic                        load_done,
  bnn_layer_sequencer_if.master       nrn,
  output logic [2:0]                  state,
  output logic                        busy,
  output logic [RESULT_W-1:0]         result,
  output logic                        result_valid
);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] L1_LAST  = IDX_W'(L1_N - 1);
  localparam logic [IDX_W-1:0] L2_LAST  = IDX_W'(L2_N - 1);
  localparam logic [IDX_W-1:0] L3_LAST  = IDX_W'(L3_N - 1);

  bnn_state_e          state_r;
  bnn_state_e          state_nx_s;
  logic                req_r;
  logic                req_nx_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_nx_s;
  logic [1:0]          lsel_r;
  logic [1:0]          lsel_nx_s;
  logic                busy_r;
  logic                busy_nx_s;
  logic [RESULT_W-1:0] result_r;
  logic [RESULT_W-1:0] result_nx_s;
  logic                rv_r;
  logic                rv_nx_s;

  logic                ack_s;
  logic                wrap_s;
  logic [IDX_W-1:0]    last_idx_s;
  logic [IDX_W-1:0]    best_idx_s;

  // Qualified acknowledge, per-layer last index and end-of-layer detection.
  // The only layer cycle with no request and index 0 is the bubble that
  // follows the final acknowledge of that layer.
  always_comb begin
    ack_s  = nrn.nrn_ack & req_r;
    wrap_s = ~req_r & (idx_r == IDX_ZERO);
    case (state_r)
      ST_L1:   last_idx_s = L1_LAST;
      ST_L2:   last_idx_s = L2_LAST;
      ST_L3:   last_idx_s = L3_LAST;
      default: last_idx_s = IDX_ZERO;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = mode ? ST_L1 : ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_L1: begin
        if (wrap_s) begin
          state_nx_s = ST_L2;
        end else begin
          state_nx_s = ST_L1;
        end
      end
      ST_L2: begin
        if (wrap_s) begin
          state_nx_s = ST_L3;
        end else begin
          state_nx_s = ST_L2;
        end
      end
      ST_L3: begin
        if (wrap_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_L3;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    req_nx_s = 1'b0;
    idx_nx_s = IDX_ZERO;
    case (state_r)
      ST_IDLE: begin
        req_nx_s = start & mode;
        idx_nx_s = IDX_ZERO;
      end
      ST_L1, ST_L2, ST_L3: begin
        if (req_r) begin
          if (ack_s) begin
            req_nx_s = 1'b0;
            idx_nx_s = (idx_r == last_idx_s) ? IDX_ZERO : (idx_r + IDX_ONE);
          end else begin
            req_nx_s = 1'b1;
            idx_nx_s = idx_r;
          end
        end else if (wrap_s) begin
          // Entering the next layer requests neuron 0 immediately; L3 goes to DONE
          req_nx_s = (state_r != ST_L3);
          idx_nx_s = IDX_ZERO;
        end else begin
          req_nx_s = 1'b1;
          idx_nx_s = idx_r;
        end
      end
      default: begin
        req_nx_s = 1'b0;
        idx_nx_s = IDX_ZERO;
      end
    endcase

    lsel_nx_s = layer_code(state_nx_s);
    busy_nx_s = (state_nx_s != ST_IDLE);
    rv_nx_s   = (state_nx_s == ST_DONE);
    if (state_nx_s == ST_DONE) begin
      result_nx_s = RESULT_W'(best_idx_s);
    end else begin
      result_nx_s = result_r;
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      req_r    <= 1'b0;
      idx_r    <= IDX_ZERO;
      lsel_r   <= LSEL_NONE;
      busy_r   <= 1'b0;
      result_r <= {RESULT_W{1'b0}};
      rv_r     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      req_r    <= req_nx_s;
      idx_r    <= idx_nx_s;
      lsel_r   <= lsel_nx_s;
      busy_r   <= busy_nx_s;
      result_r <= result_nx_s;
      rv_r     <= rv_nx_s;
    end
  end

  bnn_argmax #(
    .IDX_W   (IDX_W),
    .SCORE_W (SCORE_W)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_r == ST_IDLE),
    .en       (ack_s & (state_r == ST_L3)),
    .idx      (idx_r),
    .score    (nrn.nrn_score),
    .best_idx (best_idx_s)
  );

  assign nrn.nrn_req   = req_r;
  assign nrn.nrn_idx   = idx_r;
  assign nrn.layer_sel = lsel_r;
  assign state         = state_r;
  assign busy          = busy_r;
  assign result        = result_r;
  assign result_valid  = rv_r;

endmodule

// File: doc/bnn_layer_sequencer.md
BNN_LAYER_SEQUENCER -- requirements
Module: bnn_layer_sequencer

Interface
REQ-001 Parameter L1_N, default 128: layer-1 neuron count.
REQ-002 Parameter L2_N, default 64: layer-2 neuron count.
REQ-003 Parameter L3_N, default 10: output-layer neuron count (digit classes).
REQ-004 Parameter SCORE_W, default 10: popcount score width.
REQ-005 Parameter IDX_W, default 7: neuron index width; SHALL satisfy 2^IDX_W >= max(L1_N, L2_N, L3_N).
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  one-cycle command strobe.
REQ-009 mode  in  1  sampled with start: 0 = weight load, 1 = inference.
REQ-010 load_done  in  1  external weight loader finished.
REQ-011 nrn_req  out  1  request: datapath computes neuron nrn_idx of layer layer_sel.
REQ-012 layer_sel  out  2  active layer: 0 = L1, 1 = L2, 2 = L3; 0 outside layer states.
REQ-013 nrn_idx  out  IDX_W  neuron index under request.
REQ-014 nrn_ack  in  1  one-cycle pulse: neuron result ready.
REQ-015 nrn_score  in  SCORE_W  popcount score; valid only with nrn_ack.
REQ-016 state  out  3  current FSM state encoding.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 result  out  4  classified digit (argmax index of L3).
REQ-019 result_valid  out  1  one-cycle pulse when result updates.

Function
REQ-020 States, encoded: IDLE=0, LOAD=1, L1=2, L2=3, L3=4, DONE=5; codes 6 and 7 SHALL return to IDLE on the next cycle.
REQ-021 IDLE + start + mode=0 -> LOAD; IDLE + start + mode=1 -> L1; start in any other state is ignored.
REQ-022 LOAD -> IDLE on the first cycle with load_done=1; nrn_req stays 0 in LOAD.
REQ-023 On entry to L1, L2 or L3: nrn_idx=0; nrn_req asserts in the first cycle of the state.
REQ-024 nrn_req holds high with stable nrn_idx/layer_sel until the cycle nrn_ack=1.
REQ-025 On the cycle after an ack, nrn_req=0 (one bubble cycle); nrn_idx increments; nrn_req reasserts the following cycle.
REQ-026 Ack for index N-1 of the current layer: the next cycle enters the next state (L1->L2->L3->DONE); nrn_idx resets to 0.
REQ-027 nrn_ack while nrn_req=0 SHALL be ignored (no index advance, no score capture).
REQ-028 In L3, each acked score is compared against the running maximum; the update occurs on strictly greater only, so ties keep the lower index; the index-0 score always loads.
REQ-029 Scores are unsigned SCORE_W-bit values; no saturation or wrap is applied.
REQ-030 DONE lasts exactly one cycle: result loads the argmax index, result_valid=1, then -> IDLE.
REQ-031 result holds its value until the next DONE; it is not cleared by start.
REQ-032 Minimum inference latency, with ack in the same cycle as each request: 2*(L1_N+L2_N+L3_N)+2 cycles from start to result_valid.

Reset
REQ-033 rst=1 at any clock edge forces, on that edge: state=IDLE, nrn_req=0, nrn_idx=0, layer_sel=0, busy=0, result=0, result_valid=0, and clears the running maximum.
REQ-034 Reset during any layer SHALL abandon the inference; no result_valid SHALL be produced for it.
REQ-035 rst SHALL have priority over start and nrn_ack in the same cycle.

Structure
REQ-036 Package bnn_pkg SHALL hold the state enum typedef (3-bit) and the layer_sel codes; other BNN blocks SHALL import it.
REQ-037 The argmax tracker SHALL be a sub-module, bnn_argmax, with inputs clr, en, idx and score, and output best_idx.
REQ-038 The FSM SHALL be a single registered state plus one index counter; no combinational path from nrn_ack to nrn_req.

Verification
REQ-039 rst, then start with mode=0; load_done after 5 cycles -> state 0->1->0, busy high for 6 cycles, nrn_req never high.
REQ-040 start with mode=1, ack in the same cycle as each request, L3 scores 3,9,4,9,1,0,0,0,0,2 -> result=1, result_valid at cycle 2*(L1_N+L2_N+L3_N)+2.
REQ-041 Random 0-7 cycle ack delays, plus spurious ack pulses while nrn_req=0 -> nrn_idx sequence has no skips; layer_sel steps 0,1,2.
REQ-042 rst asserted mid-L2 (nrn_idx=20) -> next cycle state=0, nrn_idx=0; no result_valid; a following inference completes correctly.
REQ-043 start asserted during L1 and at the same cycle as DONE -> ignored; exactly one result_valid pulse.
REQ-044 All ten L3 scores equal to 5 -> result=0.
